// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter sequencer and its datapath.
package counter_pkg;

    // Sequencer states: waiting for a command, stepping, reporting completion.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

    // Direction encoding shared by the command field and the counter's mod input.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_ctrl_if.sv
// Command channel between the software-visible command source and the sequencer.
interface counter_ctrl_if #(
    parameter int STEPS_W = 4
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_dir;
    logic [STEPS_W-1:0] cmd_steps;
    logic               cmd_abort;

    // The command source drives requests and observes ready.
    modport master (
        output cmd_valid,
        output cmd_dir,
        output cmd_steps,
        output cmd_abort,
        input  cmd_ready
    );

    // The sequencer consumes requests and reports ready.
    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        input  cmd_steps,
        input  cmd_abort,
        output cmd_ready
    );
endinterface

// File: rtl/updown_counter.sv
// WIDTH-bit modulo up/down counter with a registered wrap-around flag.
module updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mod,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};

    // Step the count when enabled; wrap is high exactly while the wrapped value is shown.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (en) begin
            if (mod == DIR_UP) begin
                count <= count + 1'b1;
                wrap  <= (count == COUNT_MAX);
            end else begin
                count <= count - 1'b1;
                wrap  <= (count == '0);
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Command-driven sequencer: accepts "count N steps up/down" commands and
// drives the owned up/down counter for exactly N cycles, reporting
// completion, abort and wrap-around.
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int STEPS_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    counter_ctrl_if.slave    cmd,
    output logic             cnt_en,
    output logic             mod,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             wrap
);

    ctrl_state_t        state;
    logic [STEPS_W-1:0] rem_q;
    logic               mod_q;
    logic               aborted_q;

    // State, remaining-step count, latched direction and abort flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rem_q     <= '0;
            mod_q     <= DIR_DOWN;
            aborted_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        mod_q <= cmd.cmd_dir;
                        rem_q <= cmd.cmd_steps;
                        state <= (cmd.cmd_steps == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (cmd.cmd_abort) begin
                        aborted_q <= 1'b1;
                        rem_q     <= '0;
                        state     <= DONE;
                    end else begin
                        rem_q <= rem_q - 1'b1;
                        if (rem_q == STEPS_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    aborted_q <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode from registered state; only abort reaches cnt_en combinationally.
    always_comb begin
        cmd.cmd_ready = (state == IDLE);
        cnt_en        = (state == RUN) && !cmd.cmd_abort;
        busy          = (state != IDLE);
        done          = (state == DONE);
        aborted       = aborted_q;
        mod           = mod_q;
    end

    updown_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (cnt_en),
        .mod   (mod_q),
        .count (count),
        .wrap  (wrap)
    );

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl: stimulus pushes hand-computed per-step
// and completion expectations; a negedge monitor pops and compares them.
module tb_counter_ctrl;
    import counter_pkg::*;

    typedef struct {
        logic [2:0] count;
        logic       wrap;
    } step_t;

    typedef struct {
        logic [2:0] count;
        logic       aborted;
    } done_t;

    logic       clk_tb = 1'b0;
    logic       rst_tb = 1'b0;
    logic       cnt_en;
    logic       mod;
    logic [2:0] count;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       wrap;

    int    checks = 0;
    int    errors = 0;
    logic  en_last = 1'b0;
    step_t step_q[$];
    done_t done_q[$];

    counter_ctrl_if #(.STEPS_W(4)) cmd_bus ();

    counter_ctrl #(
        .WIDTH   (3),
        .STEPS_W (4)
    ) dut (
        .clk     (clk_tb),
        .rst     (rst_tb),
        .cmd     (cmd_bus),
        .cnt_en  (cnt_en),
        .mod     (mod),
        .count   (count),
        .busy    (busy),
        .done    (done),
        .aborted (aborted),
        .wrap    (wrap)
    );

    // Free-running 10-unit clock.
    always #5 clk_tb = ~clk_tb;

    // Hard stop in case anything stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic push_step(input logic [2:0] c, input logic w);
        step_t s;
        s.count = c;
        s.wrap  = w;
        step_q.push_back(s);
    endtask

    task automatic push_done(input logic [2:0] c, input logic a);
        done_t d;
        d.count   = c;
        d.aborted = a;
        done_q.push_back(d);
    endtask

    task automatic accept_cmd(input logic dir, input int steps);
        @(posedge clk_tb); #1;
        check_output("ready_before_accept", int'(cmd_bus.cmd_ready), 1);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_dir   = dir;
        cmd_bus.cmd_steps = 4'(steps);
        @(posedge clk_tb); #1;
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_steps = 4'd0;
    endtask

    // Issue one command; abort_cycle selects the RUN cycle that aborts (0 = none).
    task automatic apply_stimulus(input logic dir, input int steps, input int abort_cycle);
        accept_cmd(dir, steps);
        if (abort_cycle == 0) begin
            repeat (steps) begin
                @(posedge clk_tb); #1;
            end
            check_output("done_timing", int'(done), 1);
        end else begin
            repeat (abort_cycle - 1) begin
                @(posedge clk_tb); #1;
            end
            cmd_bus.cmd_abort = 1'b1;
            @(posedge clk_tb); #1;
            cmd_bus.cmd_abort = 1'b0;
            check_output("abort_done_timing", int'(done), 1);
        end
        @(posedge clk_tb); #1;
        check_output("ready_after_done", int'(cmd_bus.cmd_ready), 1);
        check_output("busy_after_done", int'(busy), 0);
    endtask

    task automatic check_reset_values();
        check_output("rst_count", int'(count), 0);
        check_output("rst_ready", int'(cmd_bus.cmd_ready), 1);
        check_output("rst_busy", int'(busy), 0);
        check_output("rst_done", int'(done), 0);
        check_output("rst_cnt_en", int'(cnt_en), 0);
        check_output("rst_mod", int'(mod), 0);
        check_output("rst_wrap", int'(wrap), 0);
        check_output("rst_aborted", int'(aborted), 0);
    endtask

    // Monitor: compare each step and each completion against the scoreboard.
    always @(negedge clk_tb) begin
        if (!rst_tb) begin
            en_last = 1'b0;
        end else begin
            if (en_last) begin
                if (step_q.size() == 0) begin
                    check_output("unexpected_step", 1, 0);
                end else begin
                    step_t s;
                    s = step_q.pop_front();
                    check_output("step_count", int'(count), int'(s.count));
                    check_output("step_wrap", int'(wrap), int'(s.wrap));
                end
            end else begin
                check_output("idle_wrap", int'(wrap), 0);
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check_output("unexpected_done", 1, 0);
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    check_output("done_count", int'(count), int'(d.count));
                    check_output("done_aborted", int'(aborted), int'(d.aborted));
                    check_output("done_ready_low", int'(cmd_bus.cmd_ready), 0);
                end
            end
            en_last = cnt_en;
        end
    end

    initial begin
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_dir   = 1'b0;
        cmd_bus.cmd_steps = 4'd0;
        cmd_bus.cmd_abort = 1'b0;
        repeat (2) @(posedge clk_tb);
        #1;
        check_reset_values();
        rst_tb = 1'b1;

        $display("[TB] up 5 from 0");
        push_step(3'd1, 1'b0); push_step(3'd2, 1'b0); push_step(3'd3, 1'b0);
        push_step(3'd4, 1'b0); push_step(3'd5, 1'b0);
        push_done(3'd5, 1'b0);
        apply_stimulus(DIR_UP, 5, 0);

        $display("[TB] up 3 from 5 (wrap to 0)");
        push_step(3'd6, 1'b0); push_step(3'd7, 1'b0); push_step(3'd0, 1'b1);
        push_done(3'd0, 1'b0);
        apply_stimulus(DIR_UP, 3, 0);

        $display("[TB] down 3 from 0");
        push_step(3'd7, 1'b1); push_step(3'd6, 1'b0); push_step(3'd5, 1'b0);
        push_done(3'd5, 1'b0);
        apply_stimulus(DIR_DOWN, 3, 0);

        $display("[TB] down 2 from 5");
        push_step(3'd4, 1'b0); push_step(3'd3, 1'b0);
        push_done(3'd3, 1'b0);
        apply_stimulus(DIR_DOWN, 2, 0);

        $display("[TB] up 8 from 3");
        push_step(3'd4, 1'b0); push_step(3'd5, 1'b0); push_step(3'd6, 1'b0);
        push_step(3'd7, 1'b0); push_step(3'd0, 1'b1); push_step(3'd1, 1'b0);
        push_step(3'd2, 1'b0); push_step(3'd3, 1'b0);
        push_done(3'd3, 1'b0);
        apply_stimulus(DIR_UP, 8, 0);

        $display("[TB] zero-step command");
        push_done(3'd3, 1'b0);
        apply_stimulus(DIR_UP, 0, 0);

        $display("[TB] down 3 from 3");
        push_step(3'd2, 1'b0); push_step(3'd1, 1'b0); push_step(3'd0, 1'b0);
        push_done(3'd0, 1'b0);
        apply_stimulus(DIR_DOWN, 3, 0);

        $display("[TB] up 10 aborted in third RUN cycle");
        push_step(3'd1, 1'b0); push_step(3'd2, 1'b0);
        push_done(3'd2, 1'b1);
        apply_stimulus(DIR_UP, 10, 3);
        check_output("mod_held", int'(mod), 1);

        $display("[TB] reset during RUN");
        push_step(3'd3, 1'b0); push_step(3'd4, 1'b0);
        accept_cmd(DIR_UP, 6);
        repeat (2) begin
            @(posedge clk_tb); #1;
        end
        @(negedge clk_tb);
        #2;
        rst_tb = 1'b0;
        #1;
        check_reset_values();
        repeat (2) @(posedge clk_tb);
        #2;
        rst_tb = 1'b1;

        $display("[TB] up 2 after reset release");
        push_step(3'd1, 1'b0); push_step(3'd2, 1'b0);
        push_done(3'd2, 1'b0);
        apply_stimulus(DIR_UP, 2, 0);

        repeat (3) @(posedge clk_tb);
        #1;
        check_output("steps_drained", step_q.size(), 0);
        check_output("dones_drained", done_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Command-driven sequencer for the team's up/down counter. It accepts "count N steps up/down" commands over a valid/ready handshake and drives the counter's step enable and direction (`mod`) for exactly N cycles. It reports completion, abort and wrap-around. It sits between a software-visible command source and the counter datapath, and owns the only copy of the count value.

## Interface

Parameters:
- `WIDTH`, default 3: counter width; count wraps modulo 2^WIDTH.
- `STEPS_W`, default 4: width of the step-count field; max 2^STEPS_W−1 steps per command.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low. Asserted (0) forces every register to its reset value immediately.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: controller can accept a command.
- `cmd_dir`  in  1: direction; 1 = up, 0 = down.
- `cmd_steps`  in  STEPS_W: number of steps.
- `cmd_abort`  in  1: stop the running command.
- `cnt_en`  out  1: counter steps at this rising edge.
- `mod`  out  1: counter direction, same encoding as `cmd_dir`.
- `count`  out  WIDTH: current counter value, registered.
- `busy`  out  1: command in progress (RUN or DONE).
- `done`  out  1: one-cycle completion pulse.
- `aborted`  out  1: qualifies `done`; command ended by abort.
- `wrap`  out  1: one-cycle pulse; last step wrapped the count.

## Operation

State machine: IDLE, RUN, DONE.

IDLE
- `cmd_ready`=1.
- Handshake: a command is accepted when `cmd_valid`=1 and `cmd_ready`=1 at a rising edge. That edge latches `dir_q`, `rem_q`=`cmd_steps`, and `mod`=`cmd_dir`.
- `cmd_steps`=0 → DONE. Otherwise → RUN.

RUN
- `cnt_en` = !`cmd_abort` (combinational).
- Each enabled edge: `count` ± 1 modulo 2^WIDTH, and `rem_q` − 1.
- Enabled edge with `rem_q`=1 → DONE.
- `cmd_abort`=1 in a RUN cycle: no step that cycle → DONE with `aborted_q` set. Abort wins over a final step in the same cycle.

DONE
- `done`=1 and `cmd_ready`=0 for exactly one cycle.
- `aborted` is valid this cycle only.
- → IDLE unconditionally.

General rules
- `cmd_abort` is ignored in IDLE and DONE.
- `cmd_valid` is ignored outside IDLE.
- Fields must be stable only at the accepting edge.
- Wrap: `wrap` is registered at the same edge that updates `count`, and is high in the cycle in which `count` shows the wrapped value.
  - Up: 2^WIDTH−1 → 0.
  - Down: 0 → 2^WIDTH−1.
- `mod` holds its last value in IDLE and DONE.
- `busy` = (state != IDLE).

Reset values: state IDLE, `count`=0, `mod`=0, `cmd_ready`=1, `cnt_en`=0, `busy`=0, `done`=0, `aborted`=0, `wrap`=0, `rem_q`=0.

Reset mid-RUN: command discarded, no `done` pulse, `count`=0.

## Timing

- Accept at edge E0.
- N>0 steps without abort:
  - RUN occupies the N cycles after E0; `cnt_en`=1 in each.
  - `count` updates at E1..EN, so the final value is visible after EN.
  - `done` is high in the cycle after EN; IDLE returns after E(N+1).
- N=0: `done` is high in the cycle after E0.
- Minimum command period: N+2 cycles (accept, N RUN, DONE).
- Back-to-back commands are accepted the cycle after DONE.
- No combinational path from `cmd_*` to `cmd_ready`.
- The only combinational input→output path is `cmd_abort` → `cnt_en`.

## Structure

- Shared package `counter_pkg`:
  - `ctrl_state_t` enum {IDLE, RUN, DONE}.
  - Direction constants `DIR_UP`=1, `DIR_DOWN`=0.
- Sub-module `updown_counter`:
  - Ports: `clk`, `rst`, `en`, `mod`, `count`, `wrap`.
  - WIDTH-parameterised, async active-low reset.
  - Instantiated once and driven by the FSM's `cnt_en` and `mod`.
- The FSM, `rem_q` down-counter and handshake live in `counter_ctrl`.

## Test plan

- Reset, then up 5 from 0 → `count` reads 1,2,3,4,5 after E1..E5; `done`=1 in the cycle after E5; `aborted`=0; `wrap` never high.
- From 0, down 3 → `count` 7,6,5; `wrap`=1 only while `count`=7; final `count`=5.
- From 3, up 8 → `count` returns to 3; exactly one `wrap` pulse, at 7→0.
- `cmd_steps`=0 → `done` the cycle after accept; `count` unchanged; `cnt_en` never high.
- Up 10 from 0, `cmd_abort` pulsed in the 3rd RUN cycle → `count`=2; `done`=1 with `aborted`=1; `cmd_ready`=1 the following cycle.
- `rst` asserted mid-RUN, asynchronous to `clk` → all outputs at reset values immediately; no `done` pulse; a new command is accepted after release.
